// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and queued LSU results onto one registered regFile write port,
// tracking pending destinations in a scoreboard for RAW stall checks.
module regfile_writeback #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int RAW      = 5,
   parameter int LQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_en,
   input  logic [RAW-1:0]  issue_rd,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [RAW-1:0]  alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [RAW-1:0]  lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic [RAW-1:0]  chk_rs1,
   input  logic [RAW-1:0]  chk_rs2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic [RAW-1:0]  writeRegSel,
   output logic [XLEN-1:0] writeData,
   output logic            writeEn,
   output logic            err
);
   localparam int PW = $clog2(LQ_DEPTH);

   logic [RAW-1:0]  rd_mem_q [LQ_DEPTH];
   logic [XLEN-1:0] data_mem_q [LQ_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     cnt_q, cnt_d;
   logic [NREG-1:0] sb_q, sb_d, sb_set, sb_clr;
   logic [RAW-1:0]  sel_q, sel_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            we_q, we_d, err_q, err_d;
   logic            full, empty, push, pop, alu_win, win;

   assign full      = cnt_q == (PW+1)'(LQ_DEPTH);
   assign empty     = cnt_q == '0;
   assign lsu_ready = rst & !full;
   assign alu_ready = rst & !full;
   assign push      = lsu_valid & lsu_ready;
   assign alu_win   = alu_valid & alu_ready;
   // A full queue forces its head out ahead of the ALU so it can never deadlock.
   assign pop       = !empty & (full | !alu_valid);
   assign win       = alu_win | pop;

   always_comb begin
      sel_d   = win ? (alu_win ? alu_rd : rd_mem_q[rd_ptr_q]) : sel_q;
      wdata_d = win ? (alu_win ? alu_data : data_mem_q[rd_ptr_q]) : wdata_q;
      we_d    = win & (sel_d != '0);
      cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      sb_set  = (issue_en && issue_rd != '0) ? NREG'(1) << issue_rd : '0;
      sb_clr  = we_q ? NREG'(1) << sel_q : '0;
      sb_d    = ((sb_q & ~sb_clr) | sb_set) & ~NREG'(1);
      err_d   = err_q | (we_d & !sb_q[sel_d]);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= lsu_rd;
         data_mem_q[wr_ptr_q] <= lsu_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         sb_q     <= '0;
         sel_q    <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PW'(push);
         rd_ptr_q <= rd_ptr_q + PW'(pop);
         cnt_q    <= cnt_d;
         sb_q     <= sb_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         err_q    <= err_d;
      end
   end

   assign rs1_busy    = sb_q[chk_rs1];
   assign rs2_busy    = sb_q[chk_rs2];
   assign writeRegSel = sel_q;
   assign writeData   = wdata_q;
   assign writeEn     = we_q;
   assign err         = err_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard bench; expected writes are queued as stimulus is driven
// and popped whenever the write port fires.
module tb_regfile_writeback;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        issue_en = 1'b0;
   logic [4:0]  issue_rd = '0;
   logic        alu_valid = 1'b0, alu_ready;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        lsu_valid = 1'b0, lsu_ready;
   logic [4:0]  lsu_rd = '0;
   logic [31:0] lsu_data = '0;
   logic [4:0]  chk_rs1 = '0, chk_rs2 = '0;
   logic        rs1_busy, rs2_busy;
   logic [4:0]  writeRegSel;
   logic [31:0] writeData;
   logic        writeEn, err;
   int          checks = 0, errors = 0;
   logic [36:0] exp_q[$];

   regfile_writeback dut (
      .clk(clk), .rst(rst), .issue_en(issue_en), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && writeEn) begin
         if (exp_q.size() == 0) check("unexpected_we", {59'd0, writeRegSel}, 64'd0);
         else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("wr_rd", {59'd0, writeRegSel}, {59'd0, e[36:32]});
            check("wr_data", {32'd0, writeData}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] r);
      issue_en = 1'b1;
      issue_rd = r;
      step();
      issue_en = 1'b0;
   endtask

   task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
      exp_q.push_back({r, d});
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         step();
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      step();
      @(negedge clk);
      check("rst_we", {63'd0, writeEn}, 64'd0);
      check("rst_sel", {59'd0, writeRegSel}, 64'd0);
      check("rst_data", {32'd0, writeData}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_lsu_rdy", {63'd0, lsu_ready}, 64'd0);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("out_alu_rdy", {63'd0, alu_ready}, 64'd1);
      check("out_lsu_rdy", {63'd0, lsu_ready}, 64'd1);

      // single ALU write and busy lifetime
      step();
      chk_rs1 = 5;
      issue(5);
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      expect_wr(5, 32'hDEADBEEF);
      @(negedge clk);
      check("x5_busy_issued", {63'd0, rs1_busy}, 64'd1);
      step();
      alu_valid = 0;
      @(negedge clk);
      check("x5_we", {63'd0, writeEn}, 64'd1);
      check("x5_busy_we", {63'd0, rs1_busy}, 64'd1);
      step();
      @(negedge clk);
      check("x5_busy_clr", {63'd0, rs1_busy}, 64'd0);

      // fill queue while ALU wins, then full-queue arbitration
      for (int r = 20; r <= 24; r++) issue(5'(r));
      for (int r = 10; r <= 13; r++) issue(5'(r));
      for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 32'hA000_0000 + i);
      expect_wr(10, 32'hB000_0000);
      expect_wr(24, 32'hA000_0004);
      for (int i = 1; i < 4; i++) expect_wr(5'(10 + i), 32'hB000_0000 + i);
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'hA000_0000 + i;
         lsu_valid = 1; lsu_rd = 5'(10 + i); lsu_data = 32'hB000_0000 + i;
         step();
      end
      alu_rd = 24; alu_data = 32'hA000_0004;
      lsu_rd = 14; lsu_data = 32'hB000_0004;
      @(negedge clk);
      check("full_lsu_rdy", {63'd0, lsu_ready}, 64'd0);
      check("full_alu_rdy", {63'd0, alu_ready}, 64'd0);
      step();
      lsu_valid = 0;
      @(negedge clk);
      check("after_pop_alu_rdy", {63'd0, alu_ready}, 64'd1);
      step();
      alu_valid = 0;
      drain();
      check("fill_err", {63'd0, err}, 64'd0);

      // ALU and LSU in the same cycle
      issue(8);
      issue(9);
      chk_rs1 = 8; chk_rs2 = 9;
      alu_valid = 1; alu_rd = 8; alu_data = 32'h1111_0008;
      lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h2222_0009;
      expect_wr(8, 32'h1111_0008);
      expect_wr(9, 32'h2222_0009);
      step();
      alu_valid = 0; lsu_valid = 0;
      @(negedge clk);
      check("dual_busy8_a", {63'd0, rs1_busy}, 64'd1);
      check("dual_busy9_a", {63'd0, rs2_busy}, 64'd1);
      step();
      @(negedge clk);
      check("dual_busy8_b", {63'd0, rs1_busy}, 64'd0);
      check("dual_busy9_b", {63'd0, rs2_busy}, 64'd1);
      step();
      @(negedge clk);
      check("dual_busy9_c", {63'd0, rs2_busy}, 64'd0);
      check("dual_q", 64'(exp_q.size()), 64'd0);

      // rd=0 results on both paths
      chk_rs1 = 0;
      issue_en = 1; issue_rd = 0;
      alu_valid = 1; alu_rd = 0; alu_data = 32'h0BAD_0000;
      lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h0BAD_0001;
      step();
      issue_en = 0; alu_valid = 0; lsu_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("x0_we", {63'd0, writeEn}, 64'd0);
         check("x0_busy", {63'd0, rs1_busy}, 64'd0);
         step();
      end
      check("x0_err", {63'd0, err}, 64'd0);

      // un-issued destination and set-beats-clear
      chk_rs1 = 7;
      alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_7777;
      expect_wr(7, 32'h7777_7777);
      step();
      alu_valid = 0;
      issue_en = 1; issue_rd = 7;
      @(negedge clk);
      check("x7_err", {63'd0, err}, 64'd1);
      step();
      issue_en = 0;
      @(negedge clk);
      check("x7_busy_kept", {63'd0, rs1_busy}, 64'd1);
      step(); step();
      @(negedge clk);
      check("x7_err_sticky", {63'd0, err}, 64'd1);

      // reset with queued loads and pending x3
      issue(3);
      for (int r = 14; r <= 16; r++) issue(5'(r));
      for (int r = 25; r <= 27; r++) issue(5'(r));
      expect_wr(25, 32'hC000_0000);
      expect_wr(26, 32'hC000_0001);
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1; alu_rd = 5'(25 + i); alu_data = 32'hC000_0000 + i;
         lsu_valid = 1; lsu_rd = 5'(14 + i); lsu_data = 32'hD000_0000 + i;
         step();
      end
      rst = 0;
      alu_valid = 0; lsu_valid = 0;
      chk_rs1 = 3; chk_rs2 = 14;
      @(negedge clk);
      check("mid_rst_we", {63'd0, writeEn}, 64'd0);
      check("mid_rst_sel", {59'd0, writeRegSel}, 64'd0);
      check("mid_rst_data", {32'd0, writeData}, 64'd0);
      check("mid_rst_err", {63'd0, err}, 64'd0);
      check("mid_rst_busy3", {63'd0, rs1_busy}, 64'd0);
      check("mid_rst_busy14", {63'd0, rs2_busy}, 64'd0);
      check("mid_rst_q", 64'(exp_q.size()), 64'd0);
      step();
      rst = 1;
      @(negedge clk);
      check("post_rst_lsu_rdy", {63'd0, lsu_ready}, 64'd1);
      check("post_rst_busy3", {63'd0, rs1_busy}, 64'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         @(negedge clk);
         check("post_rst_no_we", {63'd0, writeEn}, 64'd0);
      end
      check("final_q", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
